// File: rtl/conv_scheduler.sv
// Convolution loop-nest sequencer: buffer reads, accumulator control, output writes.
// Optional SCHED_PERF_CNT_EN builds busy/stall performance counters.
module conv_scheduler #(
  parameter int M_OUT    = 4,
  parameter int R_OUT    = 8,
  parameter int C_OUT    = 8,
  parameter int N_GRP    = 2,
  parameter int K        = 3,
  parameter int PIPE_LAT = 2,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] ifm_addr,
  output logic [ADDR_W-1:0] weight_addr,
  output logic              acc_enable,
  output logic              acc_clear,
  output logic              out_en,
  output logic [7:0]        out_wea,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       stall_cnt
);

  localparam int IN_H = R_OUT + K - 1;
  localparam int IN_W = C_OUT + K - 1;
  localparam int MW = (M_OUT > 1) ? $clog2(M_OUT) : 1;
  localparam int RW = (R_OUT > 1) ? $clog2(R_OUT) : 1;
  localparam int CW = (C_OUT > 1) ? $clog2(C_OUT) : 1;
  localparam int NW = (N_GRP > 1) ? $clog2(N_GRP) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int DW = $clog2(PIPE_LAT + 1) + 1;

  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN, DONE
  } state_t;

  typedef struct packed {
    logic          v;
    logic          first;
    logic          last;
    logic [MW-1:0] m;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
  } tap_t;

  state_t state_q, state_d;
  logic [DW-1:0] drain_q;
  logic [MW-1:0] m_q;
  logic [RW-1:0] r_q;
  logic [CW-1:0] c_q;
  logic [NW-1:0] n_q;
  logic [KW-1:0] i_q, j_q;
  logic accept;
  logic lj, li, ln, lc, lr, lm;
  logic first_tap, last_tap, last_all;
  tap_t cur, tail;
  tap_t pipe [PIPE_LAT];
  logic [7:0] lane;

  // Loop-end flags derived from the registered indices
  always_comb begin
    lj = (j_q == KW'(K - 1));
    li = (i_q == KW'(K - 1));
    ln = (n_q == NW'(N_GRP - 1));
    lc = (c_q == CW'(C_OUT - 1));
    lr = (r_q == RW'(R_OUT - 1));
    lm = (m_q == MW'(M_OUT - 1));
    first_tap = (j_q == '0) && (i_q == '0) && (n_q == '0);
    last_tap = lj && li && ln;
    last_all = last_tap && lc && lr && lm;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and control outputs
  always_comb begin
    state_d = state_q;
    busy = 1'b0;
    done = 1'b0;
    rd_en = 1'b0;
    accept = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          busy = 1'b1;
          accept = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (!pause) begin
          rd_en = 1'b1;
          if (last_all) state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_q == DW'(PIPE_LAT)) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Drain timer lets in-flight taps reach the output buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  drain_q <= '0;
    else if (state_q != DRAIN) drain_q <= '0;
    else                      drain_q <= drain_q + DW'(1);
  end

  // Loop nest m, r, c, n, i, j advancing once per issued tap
  always_ff @(posedge clk or posedge rst) begin
    if (rst || accept) begin
      m_q <= '0; r_q <= '0; c_q <= '0;
      n_q <= '0; i_q <= '0; j_q <= '0;
    end else if (rd_en) begin
      if (!lj) j_q <= j_q + KW'(1);
      else begin
        j_q <= '0;
        if (!li) i_q <= i_q + KW'(1);
        else begin
          i_q <= '0;
          if (!ln) n_q <= n_q + NW'(1);
          else begin
            n_q <= '0;
            if (!lc) c_q <= c_q + CW'(1);
            else begin
              c_q <= '0;
              if (!lr) r_q <= r_q + RW'(1);
              else begin
                r_q <= '0;
                if (!lm) m_q <= m_q + MW'(1);
                else     m_q <= '0;
              end
            end
          end
        end
      end
    end
  end

  // Buffer addresses from the current indices
  always_comb begin
    ifm_addr = ADDR_W'((32'(n_q) * IN_H + 32'(r_q) + 32'(i_q)) * IN_W
                       + 32'(c_q) + 32'(j_q));
    weight_addr = ADDR_W'(((32'(m_q) * N_GRP + 32'(n_q)) * K + 32'(i_q)) * K
                          + 32'(j_q));
  end

  // Tap descriptor entering the pipeline delay line
  always_comb begin
    cur.v = rd_en;
    cur.first = first_tap;
    cur.last = last_tap;
    cur.m = m_q;
    cur.r = r_q;
    cur.c = c_q;
    tail = pipe[PIPE_LAT-1];
    acc_enable = tail.v;
    acc_clear = tail.v & tail.first;
  end

  // Delay line matching buffer plus MAC latency; shifts even while paused
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PIPE_LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= cur;
      for (int k = 1; k < PIPE_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  // Byte lane of the neuron within its 4-channel output word
  always_comb begin
    lane = 8'h00;
    unique case (tail.m[1:0])
      2'd0: lane = 8'hC0;
      2'd1: lane = 8'h30;
      2'd2: lane = 8'h0C;
      2'd3: lane = 8'h03;
      default: lane = 8'h00;
    endcase
  end

  // Output write one cycle after the last product lands in the accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_en <= 1'b0;
      out_wea <= '0;
      out_addr <= '0;
    end else if (tail.v && tail.last) begin
      out_en <= 1'b1;
      out_wea <= lane;
      out_addr <= ADDR_W'((32'(tail.m) >> 2) * R_OUT * C_OUT
                          + 32'(tail.r) * C_OUT + 32'(tail.c));
    end else begin
      out_en <= 1'b0;
      out_wea <= '0;
      out_addr <= '0;
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] cyc_q, stall_q;

  // Saturating busy and stall counters, restarted by an accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
      stall_q <= '0;
    end else if (accept) begin
      cyc_q <= 32'd1;
      stall_q <= '0;
    end else begin
      if (busy && cyc_q != '1) cyc_q <= cyc_q + 32'd1;
      if (state_q == RUN && pause && stall_q != '1)
        stall_q <= stall_q + 32'd1;
    end
  end

  assign cycle_cnt = cyc_q;
  assign stall_cnt = stall_q;
`else
  assign cycle_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_scheduler.sv
// Directed testbench for conv_scheduler with default parameters.
// Expected values are hand-derived from the loop nest geometry.
module tb_conv_scheduler;

  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst, start, pause;
  logic busy, done, rd_en, acc_enable, acc_clear, out_en;
  logic [AW-1:0] ifm_addr, weight_addr, out_addr;
  logic [7:0] out_wea;
  logic [31:0] cycle_cnt, stall_cnt;

  always #5 clk = ~clk;

  conv_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .busy(busy), .done(done), .rd_en(rd_en),
    .ifm_addr(ifm_addr), .weight_addr(weight_addr),
    .acc_enable(acc_enable), .acc_clear(acc_clear),
    .out_en(out_en), .out_wea(out_wea), .out_addr(out_addr),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
  );

  int checks = 0;
  int passed = 0;

  int m_done, m_rd, m_wr, m_busy_gap, m_bad_wr, m_bad_acc;
  int m_accen, m_accclr, m_last_rd, m_clr_first;
  int m_pause_rd, m_pause_moved;
  logic m_done_next, m_busy_next, m_busy_at_done, m_rst_snap;
  logic [AW-1:0] m_ifm [20];
  logic [AW-1:0] m_wgt [20];
  logic [AW-1:0] m_pause_ifm, m_pause_wgt;
  logic [AW-1:0] m_addr64, m_addr255;
  logic [7:0] m_wea64, m_wea255;
  logic [31:0] m_cyc_cnt, m_stall_cnt;
  bit rd_hist [6000];
  int tap_hist [6000];

  // Run one layer; pause window, reset cycle and extra starts are optional
  task automatic run_layer(input int p_at, input int p_len,
                           input int rst_at, input int s1, input int s2);
    int lastq [$];
    int wr_idx, mm, exp_t;
    logic exp_en, exp_clr;
    logic [AW-1:0] exp_addr;
    logic [7:0] exp_wea;
    bit aborted;
    m_done = -1; m_rd = 0; m_wr = 0; m_busy_gap = 0;
    m_bad_wr = 0; m_bad_acc = 0; m_accen = 0; m_accclr = 0;
    m_last_rd = -1; m_clr_first = -1; m_pause_rd = 0;
    m_pause_moved = 0; m_rst_snap = 1'b0; m_busy_at_done = 1'bx;
    m_pause_ifm = '0; m_pause_wgt = '0;
    m_addr64 = 'x; m_addr255 = 'x; m_wea64 = 'x; m_wea255 = 'x;
    wr_idx = 0; aborted = 0;
    for (int k = 0; k < 6000; k++) begin
      rd_hist[k] = 0; tap_hist[k] = 0;
    end
    @(negedge clk);
    start = 1'b1;
    pause = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk);
      #1;
      start = (cyc == s1 || cyc == s2);
      pause = (cyc >= p_at && cyc < p_at + p_len);
      if (cyc == rst_at) begin
        rst = 1'b1;
        #1;
        m_rst_snap = |{busy, done, rd_en, acc_enable, acc_clear, out_en,
                       out_wea, out_addr, ifm_addr, weight_addr};
        aborted = 1;
        break;
      end
      @(negedge clk);
      if (rd_en === 1'b1) begin
        rd_hist[cyc] = 1;
        tap_hist[cyc] = m_rd % 18;
        m_rd++;
        if (m_rd % 18 == 0) lastq.push_back(cyc);
        m_last_rd = cyc;
      end
      if (cyc < 20) begin
        m_ifm[cyc] = ifm_addr;
        m_wgt[cyc] = weight_addr;
      end
      exp_en = (cyc >= 2) && rd_hist[cyc-2];
      exp_clr = exp_en && (tap_hist[cyc-2] == 0);
      if (acc_enable !== exp_en || acc_clear !== exp_clr) m_bad_acc++;
      if (acc_enable === 1'b1) m_accen++;
      if (acc_clear === 1'b1) begin
        m_accclr++;
        if (m_clr_first < 0) m_clr_first = cyc;
      end
      if (cyc == p_at) begin
        m_pause_ifm = ifm_addr;
        m_pause_wgt = weight_addr;
      end
      if (cyc >= p_at && cyc < p_at + p_len) begin
        if (rd_en !== 1'b0) m_pause_rd++;
        if (ifm_addr !== m_pause_ifm || weight_addr !== m_pause_wgt)
          m_pause_moved++;
      end
      if (out_en === 1'b1) begin
        exp_t = (lastq.size() > 0) ? lastq.pop_front() + 3 : -100;
        mm = wr_idx / 64;
        exp_addr = AW'((mm / 4) * 64 + wr_idx % 64);
        exp_wea = 8'hC0 >> (2 * (mm % 4));
        if (cyc != exp_t || out_addr !== exp_addr || out_wea !== exp_wea)
          m_bad_wr++;
        if (wr_idx == 64) begin
          m_addr64 = out_addr; m_wea64 = out_wea;
        end
        if (wr_idx == 255) begin
          m_addr255 = out_addr; m_wea255 = out_wea;
        end
        wr_idx++;
        m_wr++;
      end
      if (done === 1'b1) begin
        m_done = cyc;
        m_busy_at_done = busy;
        break;
      end
      if (busy !== 1'b1) m_busy_gap++;
    end
    if (!aborted) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      pause = 1'b0;
      @(negedge clk);
      m_done_next = done;
      m_busy_next = busy;
      m_cyc_cnt = cycle_cnt;
      m_stall_cnt = stall_cnt;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pause = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, rd_en, acc_enable, acc_clear, out_en, out_wea,
         out_addr, ifm_addr, weight_addr} !== '0)
      $display("FAIL reset_outputs: busy=%b done=%b rd_en=%b out_en=%b ifm=%0d",
               busy, done, rd_en, out_en, ifm_addr);
    else passed++;
    checks++;
    if (cycle_cnt !== 32'd0 || stall_cnt !== 32'd0)
      $display("FAIL reset_counters: got %0d/%0d need 0/0", cycle_cnt, stall_cnt);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_run();
    run_layer(-1, 0, -1, -1, -1);
    checks++;
    if (m_rd != 4608) $display("FAIL rd_count: got %0d need 4608", m_rd);
    else passed++;
    checks++;
    if (m_last_rd != 4607) $display("FAIL last_rd: got %0d need 4607", m_last_rd);
    else passed++;
    checks++;
    if (m_done != 4611) $display("FAIL done_cycle: got %0d need 4611", m_done);
    else passed++;
    checks++;
    if (m_wr != 256) $display("FAIL write_count: got %0d need 256", m_wr);
    else passed++;
    checks++;
    if (m_busy_gap != 0 || m_busy_at_done !== 1'b0 || m_busy_next !== 1'b0)
      $display("FAIL busy_window: gaps=%0d at_done=%b after=%b need 0/0/0",
               m_busy_gap, m_busy_at_done, m_busy_next);
    else passed++;
    checks++;
    if (m_done_next !== 1'b0) $display("FAIL done_pulse: got %b need 0", m_done_next);
    else passed++;
    checks++;
    if (m_bad_acc != 0 || m_accen != 4608 || m_accclr != 256)
      $display("FAIL acc_ctrl: bad=%0d en=%0d clr=%0d need 0/4608/256",
               m_bad_acc, m_accen, m_accclr);
    else passed++;
    checks++;
`ifdef SCHED_PERF_CNT_EN
    if (m_cyc_cnt !== 32'd4612 || m_stall_cnt !== 32'd0)
      $display("FAIL perf_full: got %0d/%0d need 4612/0", m_cyc_cnt, m_stall_cnt);
    else passed++;
`else
    if (m_cyc_cnt !== 32'd0 || m_stall_cnt !== 32'd0)
      $display("FAIL perf_off: got %0d/%0d need 0/0", m_cyc_cnt, m_stall_cnt);
    else passed++;
`endif
  endtask

  task automatic test_first_neuron();
    run_layer(-1, 0, -1, -1, -1);
    checks++;
    if (m_ifm[0] !== 16'd0 || m_wgt[0] !== 16'd0)
      $display("FAIL tap1_addr: got %0d/%0d need 0/0", m_ifm[0], m_wgt[0]);
    else passed++;
    checks++;
    if (m_ifm[1] !== 16'd1) $display("FAIL tap2_ifm: got %0d need 1", m_ifm[1]);
    else passed++;
    checks++;
    if (m_ifm[3] !== 16'd10) $display("FAIL tap4_ifm: got %0d need 10", m_ifm[3]);
    else passed++;
    checks++;
    if (m_ifm[9] !== 16'd100 || m_wgt[9] !== 16'd9)
      $display("FAIL tap10_addr: got %0d/%0d need 100/9", m_ifm[9], m_wgt[9]);
    else passed++;
    checks++;
    if (m_clr_first != 2) $display("FAIL first_clear: got %0d need 2", m_clr_first);
    else passed++;
  endtask

  task automatic test_writes();
    run_layer(-1, 0, -1, -1, -1);
    checks++;
    if (m_addr64 !== 16'd0 || m_wea64 !== 8'h30)
      $display("FAIL write_m1: got addr=%0d wea=%h need 0/30", m_addr64, m_wea64);
    else passed++;
    checks++;
    if (m_addr255 !== 16'd63 || m_wea255 !== 8'h03)
      $display("FAIL write_last: got addr=%0d wea=%h need 63/03", m_addr255, m_wea255);
    else passed++;
    checks++;
    if (m_bad_wr != 0) $display("FAIL write_seq: got %0d bad need 0", m_bad_wr);
    else passed++;
  endtask

  task automatic test_pause();
    run_layer(100, 10, -1, -1, -1);
    checks++;
    if (m_pause_rd != 0 || m_pause_moved != 0)
      $display("FAIL pause_hold: rd=%0d moved=%0d need 0/0", m_pause_rd, m_pause_moved);
    else passed++;
    checks++;
    if (m_pause_ifm !== 16'd106 || m_pause_wgt !== 16'd10)
      $display("FAIL pause_addr: got %0d/%0d need 106/10", m_pause_ifm, m_pause_wgt);
    else passed++;
    checks++;
    if (m_done != 4621 || m_rd != 4608)
      $display("FAIL pause_done: got %0d rd=%0d need 4621/4608", m_done, m_rd);
    else passed++;
    checks++;
    if (m_bad_acc != 0 || m_bad_wr != 0 || m_wr != 256)
      $display("FAIL pause_pipe: acc=%0d wr=%0d n=%0d need 0/0/256",
               m_bad_acc, m_bad_wr, m_wr);
    else passed++;
    checks++;
`ifdef SCHED_PERF_CNT_EN
    if (m_cyc_cnt !== 32'd4622 || m_stall_cnt !== 32'd10)
      $display("FAIL perf_pause: got %0d/%0d need 4622/10", m_cyc_cnt, m_stall_cnt);
    else passed++;
`else
    if (m_cyc_cnt !== 32'd0 || m_stall_cnt !== 32'd0)
      $display("FAIL perf_off_pause: got %0d/%0d need 0/0", m_cyc_cnt, m_stall_cnt);
    else passed++;
`endif
  endtask

  task automatic test_reset_mid_run();
    int active;
    run_layer(-1, 0, 500, -1, -1);
    checks++;
    if (m_rst_snap !== 1'b0) $display("FAIL rst_async: outputs=%b need 0", m_rst_snap);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    active = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_en !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) active++;
    end
    checks++;
    if (active != 0) $display("FAIL rst_quiet: got %0d active cycles need 0", active);
    else passed++;
    run_layer(-1, 0, -1, -1, -1);
    checks++;
    if (m_done != 4611 || m_wr != 256 || m_bad_wr != 0)
      $display("FAIL rst_rerun: done=%0d wr=%0d bad=%0d need 4611/256/0",
               m_done, m_wr, m_bad_wr);
    else passed++;
  endtask

  task automatic test_start_ignored();
    int active;
    run_layer(-1, 0, -1, 1000, 4611);
    checks++;
    if (m_done != 4611 || m_rd != 4608 || m_wr != 256 || m_bad_wr != 0)
      $display("FAIL restart_run: done=%0d rd=%0d wr=%0d bad=%0d need 4611/4608/256/0",
               m_done, m_rd, m_wr, m_bad_wr);
    else passed++;
    checks++;
    if (m_busy_at_done !== 1'b0) $display("FAIL restart_done_busy: got %b need 0", m_busy_at_done);
    else passed++;
    active = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0) active++;
    end
    checks++;
    if (active != 0) $display("FAIL restart_idle: got %0d active cycles need 0", active);
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    test_reset();
    test_full_run();
    test_first_neuron();
    test_writes();
    test_pause();
    test_reset_mid_run();
    test_start_ignored();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
